// File: rtl/mips_pkg.sv
// mips_pkg: opcode, forward-select and nop constants shared by the MIPS pipeline stages.
package mips_pkg;
    localparam logic [5:0]  OP_BEQ  = 6'b000100;
    localparam logic [5:0]  OP_BNE  = 6'b000101;
    localparam logic [1:0]  FWD_RF  = 2'b00;
    localparam logic [1:0]  FWD_WB  = 2'b01;
    localparam logic [1:0]  FWD_MEM = 2'b10;
    localparam logic [31:0] NOP     = 32'h0;

    // A producer writing $0 never creates a dependency.
    function automatic logic reg_hit(logic [4:0] rd, logic [4:0] rs, logic [4:0] rt);
        return rd != 5'd0 && (rd == rs || rd == rt);
    endfunction
endpackage

// File: rtl/id_branch_stage_if.sv
// id_branch_stage_if: pipeline-side signals of the ID branch/hazard stage.
interface id_branch_stage_if #(
    parameter int DW    = 32,
    parameter int CNT_W = 32
);
    logic [DW-1:0]    instr_if, pcplus4_if, rd1_id, rd2_id, alu_out_mem, result_wb;
    logic [1:0]       forwarda, forwardb;
    logic             RegWriteEX, MemReadEX, MemReadMEM;
    logic [4:0]       writeregEX, writeregMEM;
    logic [DW-1:0]    instr_id, pcplus4_id, branch_target;
    logic             beqID, bneID, pc_write, ifid_write, idex_bubble, pcsrc;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    modport master (
        output instr_if, pcplus4_if, rd1_id, rd2_id, alu_out_mem, result_wb,
               forwarda, forwardb, RegWriteEX, MemReadEX, MemReadMEM, writeregEX, writeregMEM,
        input  instr_id, pcplus4_id, branch_target, beqID, bneID, pc_write, ifid_write,
               idex_bubble, pcsrc, stall_cnt, flush_cnt
    );

    modport slave (
        input  instr_if, pcplus4_if, rd1_id, rd2_id, alu_out_mem, result_wb,
               forwarda, forwardb, RegWriteEX, MemReadEX, MemReadMEM, writeregEX, writeregMEM,
        output instr_id, pcplus4_id, branch_target, beqID, bneID, pc_write, ifid_write,
               idex_bubble, pcsrc, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/id_branch_stage_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset)
            r_count <= '0;
        else if (inc && r_count != '1)
            r_count <= r_count + CNT_W'(1);
    end

    assign count = r_count;
endmodule

// File: rtl/id_branch_stage.sv
// id_branch_stage: IF/ID register, ID-stage beq/bne resolution and load-use/branch hazard control.
// A taken branch squashes its single delay slot; stalls and flushes are counted.
module id_branch_stage
    import mips_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    id_branch_stage_if.slave bus
);
    logic [DW-1:0]    r_instr_id, r_pcplus4_id, w_op_a, w_op_b;
    logic [4:0]       w_rs, w_rt;
    logic [15:0]      w_imm;
    logic             w_beq, w_bne, w_br, w_taken;
    logic             w_loaduse, w_br_ex, w_br_mem, w_stall, w_pcsrc;
    logic [CNT_W-1:0] w_stall_cnt, w_flush_cnt;

    assign w_rs  = r_instr_id[25:21];
    assign w_rt  = r_instr_id[20:16];
    assign w_imm = r_instr_id[15:0];
    assign w_beq = r_instr_id[31:26] == OP_BEQ;
    assign w_bne = r_instr_id[31:26] == OP_BNE;
    assign w_br  = w_beq | w_bne;

    // Select 2'b11 is unused and falls back to the register file.
    assign w_op_a = bus.forwarda == FWD_WB  ? bus.result_wb :
                    bus.forwarda == FWD_MEM ? bus.alu_out_mem : bus.rd1_id;
    assign w_op_b = bus.forwardb == FWD_WB  ? bus.result_wb :
                    bus.forwardb == FWD_MEM ? bus.alu_out_mem : bus.rd2_id;
    assign w_taken = w_beq ? w_op_a == w_op_b : w_op_a != w_op_b;

    // A branch compares in ID, so it must also wait for ALU results in EX and loads in MEM.
    assign w_loaduse = bus.MemReadEX & reg_hit(bus.writeregEX, w_rs, w_rt);
    assign w_br_ex   = w_br & bus.RegWriteEX & reg_hit(bus.writeregEX, w_rs, w_rt);
    assign w_br_mem  = w_br & bus.MemReadMEM & reg_hit(bus.writeregMEM, w_rs, w_rt);
    assign w_stall   = w_loaduse | w_br_ex | w_br_mem;
    assign w_pcsrc   = w_br & w_taken & ~w_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr_id   <= NOP[DW-1:0];
            r_pcplus4_id <= '0;
        end else if (w_pcsrc) begin
            r_instr_id   <= NOP[DW-1:0];
            r_pcplus4_id <= bus.pcplus4_if;
        end else if (!w_stall) begin
            r_instr_id   <= bus.instr_if;
            r_pcplus4_id <= bus.pcplus4_if;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall),
        .count (w_stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_pcsrc),
        .count (w_flush_cnt)
    );

    assign bus.instr_id      = r_instr_id;
    assign bus.pcplus4_id    = r_pcplus4_id;
    assign bus.beqID         = w_beq;
    assign bus.bneID         = w_bne;
    assign bus.pc_write      = ~w_stall;
    assign bus.ifid_write    = ~w_stall;
    assign bus.idex_bubble   = w_stall;
    assign bus.pcsrc         = w_pcsrc;
    assign bus.branch_target = r_pcplus4_id + {{(DW-18){w_imm[15]}}, w_imm, 2'b00};
    assign bus.stall_cnt     = w_stall_cnt;
    assign bus.flush_cnt     = w_flush_cnt;
endmodule

// File: tb/tb_id_branch_stage.sv
// tb_id_branch_stage: vector table, hand sequences and random stimulus against a behavioural model.
module tb_id_branch_stage;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    id_branch_stage_if #(.DW(32), .CNT_W(32)) bus ();
    id_branch_stage_if #(.DW(32), .CNT_W(3))  bus3 ();

    id_branch_stage #(.DW(32), .CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    id_branch_stage #(.DW(32), .CNT_W(3))  dut3 (.clk(clk), .reset(reset), .bus(bus3));

    // Narrow-counter copy sees identical stimulus so saturation shows up quickly.
    assign bus3.instr_if    = bus.instr_if;
    assign bus3.pcplus4_if  = bus.pcplus4_if;
    assign bus3.rd1_id      = bus.rd1_id;
    assign bus3.rd2_id      = bus.rd2_id;
    assign bus3.alu_out_mem = bus.alu_out_mem;
    assign bus3.result_wb   = bus.result_wb;
    assign bus3.forwarda    = bus.forwarda;
    assign bus3.forwardb    = bus.forwardb;
    assign bus3.RegWriteEX  = bus.RegWriteEX;
    assign bus3.MemReadEX   = bus.MemReadEX;
    assign bus3.MemReadMEM  = bus.MemReadMEM;
    assign bus3.writeregEX  = bus.writeregEX;
    assign bus3.writeregMEM = bus.writeregMEM;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural model state
    logic [31:0] m_instr, m_pc4;
    longint      m_sc, m_fc;
    int          m_sc3, m_fc3;

    typedef struct packed {
        logic        stall;
        logic        pcsrc;
        logic        beq;
        logic        bne;
        logic [31:0] tgt;
    } exp_t;

    typedef struct {
        logic [31:0] instr, pc4, rd1, rd2, mem, wb;
        logic [1:0]  fa, fb;
        logic        rwex, mrex;
        logic [4:0]  wex;
        logic        mrmem;
        logic [4:0]  wmem;
        logic        xs, xp;
        logic [31:0] xt;
    } vec_t;

    vec_t vt[16];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic chk1(string nm, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] pick(logic [1:0] sel, logic [31:0] rf);
        return sel == 2'd1 ? bus.result_wb : sel == 2'd2 ? bus.alu_out_mem : rf;
    endfunction

    function automatic logic depends(int r, int rs, int rt);
        return r != 0 && (r == rs || r == rt);
    endfunction

    function automatic exp_t ref_eval();
        exp_t        e;
        int          op, rs, rt, wex, wmem;
        logic [31:0] a, b;
        logic        br;
        op   = int'(m_instr >> 26);
        rs   = int'((m_instr >> 21) & 32'd31);
        rt   = int'((m_instr >> 16) & 32'd31);
        wex  = int'(bus.writeregEX);
        wmem = int'(bus.writeregMEM);
        a    = pick(bus.forwarda, bus.rd1_id);
        b    = pick(bus.forwardb, bus.rd2_id);
        e.beq   = op == 4;
        e.bne   = op == 5;
        br      = e.beq | e.bne;
        e.stall = (bus.MemReadEX && depends(wex, rs, rt)) ||
                  (br && bus.RegWriteEX && depends(wex, rs, rt)) ||
                  (br && bus.MemReadMEM && depends(wmem, rs, rt));
        e.pcsrc = br && !e.stall && (e.beq ? a == b : a != b);
        e.tgt   = m_pc4 + 32'(4 * int'($signed(m_instr[15:0])));
        return e;
    endfunction

    task automatic model_edge(exp_t e);
        if (reset) begin
            m_instr = 32'h0; m_pc4 = 32'h0;
            m_sc = 0; m_fc = 0; m_sc3 = 0; m_fc3 = 0;
        end else begin
            if (e.pcsrc) begin
                m_instr = 32'h0; m_pc4 = bus.pcplus4_if;
            end else if (!e.stall) begin
                m_instr = bus.instr_if; m_pc4 = bus.pcplus4_if;
            end
            if (e.stall && m_sc < 64'hFFFF_FFFF) m_sc++;
            if (e.pcsrc && m_fc < 64'hFFFF_FFFF) m_fc++;
            if (e.stall && m_sc3 < 7) m_sc3++;
            if (e.pcsrc && m_fc3 < 7) m_fc3++;
        end
    endtask

    task automatic cyc(bit do_check);
        exp_t e;
        @(negedge clk);
        e = ref_eval();
        if (do_check) begin
            chk("instr_id", bus.instr_id, m_instr);
            chk("pcplus4_id", bus.pcplus4_id, m_pc4);
            chk1("beqID", bus.beqID, e.beq);
            chk1("bneID", bus.bneID, e.bne);
            chk1("pc_write", bus.pc_write, !e.stall);
            chk1("ifid_write", bus.ifid_write, !e.stall);
            chk1("idex_bubble", bus.idex_bubble, e.stall);
            chk1("pcsrc", bus.pcsrc, e.pcsrc);
            chk("branch_target", bus.branch_target, e.tgt);
            chk("stall_cnt", bus.stall_cnt, 32'(m_sc));
            chk("flush_cnt", bus.flush_cnt, 32'(m_fc));
            chk("stall_cnt_w3", 32'(bus3.stall_cnt), 32'(m_sc3));
            chk("flush_cnt_w3", 32'(bus3.flush_cnt), 32'(m_fc3));
        end
        @(posedge clk);
        model_edge(e);
        #1;
    endtask

    task automatic idle();
        bus.rd1_id = 32'h0; bus.rd2_id = 32'h0; bus.alu_out_mem = 32'h0; bus.result_wb = 32'h0;
        bus.forwarda = 2'd0; bus.forwardb = 2'd0;
        bus.RegWriteEX = 1'b0; bus.MemReadEX = 1'b0; bus.writeregEX = 5'd0;
        bus.MemReadMEM = 1'b0; bus.writeregMEM = 5'd0;
    endtask

    task automatic load_id(logic [31:0] instr, logic [31:0] pc4);
        reset = 1'b1; idle(); cyc(1);
        reset = 1'b0; bus.instr_if = instr; bus.pcplus4_if = pc4; cyc(1);
    endtask

    initial begin
        logic [5:0]  op;
        logic [31:0] mark;
        int          k;
        checks = 0; failures = 0;

        //      instr         pc4            rd1    rd2    mem    wb     fa    fb    rwx   mrx   wex   mrm   wmem  xs    xp    tgt
        vt[0]  = '{32'h11090003, 32'h10, 32'd7, 32'd7, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h1C};
        vt[1]  = '{32'h15090003, 32'h10, 32'd9, 32'd5, 32'd5, 32'd0, 2'd2, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h1C};
        vt[2]  = '{32'h11090003, 32'h10, 32'd1, 32'd2, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h1C};
        vt[3]  = '{32'h15090003, 32'h10, 32'd1, 32'd2, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h1C};
        vt[4]  = '{32'h1109FFFF, 32'h100, 32'd7, 32'd7, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'hFC};
        vt[5]  = '{32'h11090003, 32'h10, 32'd7, 32'd7, 32'd0, 32'd0, 2'd0, 2'd0, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b1, 1'b0, 32'h1C};
        vt[6]  = '{32'h11090003, 32'h10, 32'd7, 32'd7, 32'd0, 32'd0, 2'd0, 2'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h1C};
        vt[7]  = '{32'h01095020, 32'h20, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 1'b0, 32'h140A0};
        vt[8]  = '{32'h01095020, 32'h20, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0, 32'h140A0};
        vt[9]  = '{32'h01095020, 32'h20, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0, 32'h140A0};
        vt[10] = '{32'h11090003, 32'h10, 32'd7, 32'd7, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 32'h1C};
        vt[11] = '{32'h11090003, 32'h10, 32'd7, 32'd7, 32'd2, 32'd1, 2'd3, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h1C};
        vt[12] = '{32'h11090003, 32'h10, 32'd3, 32'd0, 32'd0, 32'd3, 2'd0, 2'd1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h1C};
        vt[13] = '{32'h11090010, 32'hFFFFFFF0, 32'd7, 32'd7, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h30};
        vt[14] = '{32'h15090003, 32'h10, 32'd1, 32'd2, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 1'b0, 32'h1C};
        vt[15] = '{32'h10090003, 32'h10, 32'd7, 32'd7, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h1C};

        // Reset state and first fetch
        reset = 1'b1; idle();
        bus.instr_if = 32'h0; bus.pcplus4_if = 32'h0;
        cyc(0);
        cyc(1);
        chk("rst_instr_id", bus.instr_id, 32'h0);
        chk("rst_pcplus4_id", bus.pcplus4_id, 32'h0);
        chk1("rst_pc_write", bus.pc_write, 1'b1);
        chk1("rst_idex_bubble", bus.idex_bubble, 1'b0);
        chk1("rst_pcsrc", bus.pcsrc, 1'b0);
        chk("rst_stall_cnt", bus.stall_cnt, 32'h0);
        chk("rst_flush_cnt", bus.flush_cnt, 32'h0);
        reset = 1'b0; bus.instr_if = 32'h20080005; bus.pcplus4_if = 32'h4;
        cyc(1);
        chk("first_instr_id", bus.instr_id, 32'h20080005);
        chk("first_pcplus4_id", bus.pcplus4_id, 32'h4);
        chk1("first_no_stall", bus.pc_write, 1'b1);

        // Vector table
        foreach (vt[i]) begin
            load_id(vt[i].instr, vt[i].pc4);
            bus.rd1_id = vt[i].rd1; bus.rd2_id = vt[i].rd2;
            bus.alu_out_mem = vt[i].mem; bus.result_wb = vt[i].wb;
            bus.forwarda = vt[i].fa; bus.forwardb = vt[i].fb;
            bus.RegWriteEX = vt[i].rwex; bus.MemReadEX = vt[i].mrex; bus.writeregEX = vt[i].wex;
            bus.MemReadMEM = vt[i].mrmem; bus.writeregMEM = vt[i].wmem;
            mark = 32'hA5A50000 | 32'(i);
            bus.instr_if = mark; bus.pcplus4_if = 32'h1000 + 32'(4 * i);
            #1;
            chk1("vec_stall", bus.idex_bubble, vt[i].xs);
            chk1("vec_pc_write", bus.pc_write, !vt[i].xs);
            chk1("vec_pcsrc", bus.pcsrc, vt[i].xp);
            chk("vec_target", bus.branch_target, vt[i].xt);
            cyc(1);
            chk("vec_next_instr", bus.instr_id, vt[i].xp ? 32'h0 : vt[i].xs ? vt[i].instr : mark);
            chk("vec_next_pc4", bus.pcplus4_id, vt[i].xs && !vt[i].xp ? vt[i].pc4 : 32'h1000 + 32'(4 * i));
        end

        // Load feeding a branch: two stall cycles, then resolve via WB forwarding
        load_id(32'h11000002, 32'h40);
        bus.RegWriteEX = 1'b1; bus.MemReadEX = 1'b1; bus.writeregEX = 5'd8;
        bus.instr_if = 32'h00001234; bus.pcplus4_if = 32'h44;
        #1;
        chk1("lu_c1_bubble", bus.idex_bubble, 1'b1);
        chk1("lu_c1_pc_write", bus.pc_write, 1'b0);
        cyc(1);
        bus.RegWriteEX = 1'b0; bus.MemReadEX = 1'b0; bus.writeregEX = 5'd0;
        bus.MemReadMEM = 1'b1; bus.writeregMEM = 5'd8;
        #1;
        chk1("lu_c2_bubble", bus.idex_bubble, 1'b1);
        chk1("lu_c2_pcsrc", bus.pcsrc, 1'b0);
        cyc(1);
        bus.MemReadMEM = 1'b0; bus.writeregMEM = 5'd0;
        bus.forwarda = 2'd1; bus.result_wb = 32'h0; bus.rd2_id = 32'h0; bus.rd1_id = 32'hDEAD;
        #1;
        chk1("lu_c3_pcsrc", bus.pcsrc, 1'b1);
        chk("lu_c3_stall_cnt", bus.stall_cnt, 32'd2);
        chk("lu_c3_target", bus.branch_target, 32'h48);
        cyc(1);
        chk("lu_flushed", bus.instr_id, 32'h0);
        chk("lu_flush_cnt", bus.flush_cnt, 32'd1);

        // Long load-use stall saturates the narrow counter; reset mid-stall clears it
        load_id(32'h01095020, 32'h80);
        bus.MemReadEX = 1'b1; bus.writeregEX = 5'd8;
        bus.instr_if = 32'h00005555; bus.pcplus4_if = 32'h84;
        for (int n = 0; n < 10; n++) cyc(1);
        chk("sat_w3", 32'(bus3.stall_cnt), 32'd7);
        chk("sat_w32", bus.stall_cnt, 32'd10);
        chk("sat_held", bus.instr_id, 32'h01095020);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        #1;
        chk("midrst_instr_id", bus.instr_id, 32'h0);
        chk("midrst_stall_cnt", bus.stall_cnt, 32'h0);
        chk1("midrst_pc_write", bus.pc_write, 1'b1);
        cyc(1);

        // Random stimulus against the model
        for (int n = 0; n < 400; n++) begin
            k  = $urandom_range(0, 4);
            op = k == 0 ? 6'h04 : k == 1 ? 6'h05 : k == 2 ? 6'h00 : k == 3 ? 6'h23 : 6'($urandom);
            bus.instr_if    = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
            bus.pcplus4_if  = $urandom;
            reset           = $urandom_range(0, 49) == 0;
            bus.rd1_id      = $urandom_range(0, 2);
            bus.rd2_id      = $urandom_range(0, 2);
            bus.alu_out_mem = $urandom_range(0, 2);
            bus.result_wb   = $urandom_range(0, 2);
            bus.forwarda    = 2'($urandom);
            bus.forwardb    = 2'($urandom);
            bus.RegWriteEX  = $urandom_range(0, 3) == 0;
            bus.MemReadEX   = $urandom_range(0, 4) == 0;
            bus.writeregEX  = 5'($urandom_range(0, 3));
            bus.MemReadMEM  = $urandom_range(0, 4) == 0;
            bus.writeregMEM = 5'($urandom_range(0, 3));
            cyc(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
